dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences the team's single-clock dual-port RAM (one write port, one read port, DATA_WIDTH x ADDRESS_DEPTH).
- Converts push/pop requests into RAM write-enable, read-enable and address strobes.
- Tracks occupancy and flags full/empty.
- Sits beside the RAM instance in the parent; the RAM's data ports connect straight to the FIFO users, except wr_data, which passes through this block.

Parameters:
- ADDRESS_DEPTH, 16, number of RAM words; must equal 2**ADDRESS_SIZE.
- DATA_WIDTH, 8, RAM word width.
- ADDRESS_SIZE, 4, RAM address width.
- ALMOST_FULL_LVL, 14, occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  request to write push_data.
- push_data  in  DATA_WIDTH  data to enqueue.
- pop  in  1  request to read oldest entry.
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data (combinational copy of push_data).
- ram_we  out  1  to RAM we.
- ram_wr_addr  out  ADDRESS_SIZE  to RAM wr_addr.
- ram_re  out  1  to RAM re.
- ram_rd_addr  out  ADDRESS_SIZE  to RAM rd_addr.
- rd_valid  out  1  RAM rd_data holds the popped word this cycle.
- full  out  1  occupancy == ADDRESS_DEPTH.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy >= ALMOST_FULL_LVL.
- count  out  ADDRESS_SIZE+1  current occupancy, 0..ADDRESS_DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset values, applied on a clk edge with rst=1:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_full = 0.
  - rd_valid = 0, overflow = 0, underflow = 0.
  - ram_we and ram_re low during rst.
- rst has priority over push/pop in the same cycle. Reset mid-operation discards any pending rd_valid. RAM contents are not cleared by this block.
- Pointers are ADDRESS_SIZE+1 bits.
  - RAM addresses are the low ADDRESS_SIZE bits.
  - Pointers wrap naturally: address 15 -> 0, MSB toggles.
- Acceptance uses registered flags from the current cycle:
  - push_ok = push & ~full
  - pop_ok = pop & ~empty
- ram_we = push_ok and ram_wr_addr = wr_ptr[ADDRESS_SIZE-1:0], both combinational. wr_ptr increments at the clock edge when push_ok.
- ram_re = pop_ok and ram_rd_addr = rd_ptr[ADDRESS_SIZE-1:0], both combinational. rd_ptr increments at the clock edge when pop_ok.
- Read latency: the RAM registers rd_data on the edge where re is sampled. rd_valid is a register of pop_ok, so it is high exactly the cycle after the pop is accepted. Back-to-back pops give back-to-back rd_valid.
- count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - unchanged on both or neither.
- full, empty and almost_full are registered and derived from next-state count.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted; count unchanged; the read address differs from the write address.
  - Full: pop accepted, push rejected, overflow set; next cycle count = DEPTH-1.
  - Empty: push accepted, pop rejected, underflow set. The word is not forwarded in the same cycle; first readable on the next cycle.
- Rejected requests have no effect on pointers, count or RAM strobes.
- overflow and underflow stay set until rst.

Decomposition:
- Package dpram_pkg holds:
  - default ADDRESS_DEPTH, DATA_WIDTH and ADDRESS_SIZE constants shared with dual_port_ram;
  - pointer-width constant PTR_W = ADDRESS_SIZE+1.
- One natural sub-module: fifo_ptr, an ADDRESS_SIZE+1-bit pointer register with synchronous reset and increment enable, instantiated twice (write and read pointers).
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset check: assert rst for 2 cycles with push=1 and pop=1 held -> count=0, empty=1, full=0, rd_valid=0, no ram_we/ram_re pulses during rst.
- Single transfer: push 8'h0F, then pop -> ram_we with ram_wr_addr=0, then ram_re with ram_rd_addr=0; rd_valid high the next cycle with RAM rd_data=8'h0F; empty returns to 1.
- Fill to full: 16 pushes of 8'h00..8'h0F -> almost_full at count=14, full at count=16. A 17th push gives no ram_we, sets overflow, count stays 16.
- Drain and wrap: pop all 16 -> data 8'h00..8'h0F in order on consecutive rd_valid cycles. A 17th pop sets underflow. Then 4 more push/pop pairs use addresses 0..3 again (pointer MSB toggled) with correct data.
- Simultaneous at boundaries:
  - Push+pop when full -> count 15, overflow=1.
  - Push+pop when empty -> count 1, underflow=1, no rd_valid.
  - Push+pop at count=5 -> count stays 5, both strobes high.
- Reset mid-stream: pop accepted in cycle N, rst in cycle N+1 -> rd_valid=0 in N+1 and after; pointers, count and sticky flags cleared.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants for the dual-port RAM and its FIFO controller.
// Pointer width carries one extra wrap bit above the RAM address.
package dpram_pkg;
  localparam int DPRAM_DEPTH = 16;
  localparam int DPRAM_WIDTH = 8;
  localparam int DPRAM_ASIZE = 4;
  localparam int PTR_W       = DPRAM_ASIZE + 1;
endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: wrap-bit counter with sync reset and increment enable.
// The MSB toggles each time the address field wraps.
module fifo_ptr
  import dpram_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller sequencing a single-clock dual-port RAM.
// Occupancy is the pointer difference; flags are registered.
module dpram_fifo_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDRESS_DEPTH   = DPRAM_DEPTH,
  parameter int DATA_WIDTH      = DPRAM_WIDTH,
  parameter int ADDRESS_SIZE    = DPRAM_ASIZE,
  parameter int ALMOST_FULL_LVL = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic                    ram_we,
  output logic [ADDRESS_SIZE-1:0] ram_wr_addr,
  output logic                    ram_re,
  output logic [ADDRESS_SIZE-1:0] ram_rd_addr,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = ADDRESS_SIZE + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(ADDRESS_DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL_LVL);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;
  logic          rd_valid_q;

  assign push_ok = push & ~full & ~rst;
  assign pop_ok  = pop & ~empty & ~rst;

  assign ram_wr_data = push_data;
  assign ram_we      = push_ok;
  assign ram_wr_addr = wr_ptr[ADDRESS_SIZE-1:0];
  assign ram_re      = pop_ok;
  assign ram_rd_addr = rd_ptr[ADDRESS_SIZE-1:0];

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  assign count = wr_ptr - rd_ptr;

  always_comb begin
    count_nxt = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + PW'(1);
      2'b01:   count_nxt = count - PW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      full        <= (count_nxt == DEPTH_C);
      empty       <= (count_nxt == '0);
      almost_full <= (count_nxt >= AF_C);
      rd_valid_q  <= pop_ok;
      overflow    <= overflow | (push & full);
      underflow   <= underflow | (pop & empty);
    end
  end

  // A reset arriving the cycle after a pop kills that read.
  assign rd_valid = rd_valid_q & ~rst;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural RAM.
// Each step drives inputs, checks strobes, clocks, checks state.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] ram_wr_data;
  logic       ram_we;
  logic [3:0] ram_wr_addr;
  logic       ram_re;
  logic [3:0] ram_rd_addr;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  logic [7:0] mem [16];
  logic [7:0] rd_data;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .ram_wr_data (ram_wr_data),
    .ram_we      (ram_we),
    .ram_wr_addr (ram_wr_addr),
    .ram_re      (ram_re),
    .ram_rd_addr (ram_rd_addr),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_re) rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_rdv"}, 32'(rd_valid), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_unf"}, 32'(underflow), 0);
  endtask

  initial begin
    rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = 8'hAA;
    // reset with requests held
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_re", 32'(ram_re), 0);
      tick();
      chk_reset_state("rst");
    end
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    tick();

    // single transfer
    push = 1'b1; push_data = 8'h0F; #1;
    chk("st_we", 32'(ram_we), 1);
    chk("st_waddr", 32'(ram_wr_addr), 0);
    chk("st_wdata", 32'(ram_wr_data), 32'h0F);
    tick(); push = 1'b0;
    chk("st_cnt1", 32'(count), 1);
    chk("st_empty0", 32'(empty), 0);
    pop = 1'b1; #1;
    chk("st_re", 32'(ram_re), 1);
    chk("st_raddr", 32'(ram_rd_addr), 0);
    tick(); pop = 1'b0;
    chk("st_rdv", 32'(rd_valid), 1);
    chk("st_data", 32'(rd_data), 32'h0F);
    chk("st_empty1", 32'(empty), 1);
    chk("st_cnt0", 32'(count), 0);
    tick();
    chk("st_rdv0", 32'(rd_valid), 0);

    rst = 1'b1; tick(); rst = 1'b0;

    // fill to full
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; push_data = 8'(i); #1;
      chk("fill_we", 32'(ram_we), 1);
      chk("fill_waddr", 32'(ram_wr_addr), 32'(i));
      tick();
      chk("fill_cnt", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    push_data = 8'hEE; #1;
    chk("ovf_we", 32'(ram_we), 0);
    tick(); push = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_cnt", 32'(count), 16);
    chk("ovf_full", 32'(full), 1);

    // drain, back-to-back reads
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1; #1;
      chk("drn_re", 32'(ram_re), 1);
      chk("drn_raddr", 32'(ram_rd_addr), 32'(i));
      tick();
      chk("drn_rdv", 32'(rd_valid), 1);
      chk("drn_data", 32'(rd_data), 32'(i));
      chk("drn_cnt", 32'(count), 32'(15 - i));
    end
    chk("drn_empty", 32'(empty), 1);
    #1;
    chk("unf_re", 32'(ram_re), 0);
    tick(); pop = 1'b0;
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_rdv", 32'(rd_valid), 0);
    chk("unf_cnt", 32'(count), 0);

    // wrap: pointer MSB now set, addresses restart at 0
    for (int j = 0; j < 4; j++) begin
      push = 1'b1; push_data = 8'hA0 + 8'(j); #1;
      chk("wrap_waddr", 32'(ram_wr_addr), 32'(j));
      tick(); push = 1'b0; pop = 1'b1; #1;
      chk("wrap_raddr", 32'(ram_rd_addr), 32'(j));
      tick(); pop = 1'b0;
      chk("wrap_rdv", 32'(rd_valid), 1);
      chk("wrap_data", 32'(rd_data), 32'hA0 + 32'(j));
    end

    // simultaneous push+pop while full
    rst = 1'b1; tick(); rst = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_data = 8'h30 + 8'(i); tick();
    end
    chk("sf_full", 32'(full), 1);
    pop = 1'b1; #1;
    chk("sf_we", 32'(ram_we), 0);
    chk("sf_re", 32'(ram_re), 1);
    tick(); push = 1'b0;
    chk("sf_cnt", 32'(count), 15);
    chk("sf_ovf", 32'(overflow), 1);
    chk("sf_rdv", 32'(rd_valid), 1);
    chk("sf_data", 32'(rd_data), 32'h30);
    for (int i = 0; i < 15; i++) tick();
    pop = 1'b0;
    chk("se_pre_empty", 32'(empty), 1);
    chk("se_pre_unf", 32'(underflow), 0);
    tick();

    // simultaneous push+pop while empty
    push = 1'b1; pop = 1'b1; push_data = 8'h55; #1;
    chk("se_we", 32'(ram_we), 1);
    chk("se_re", 32'(ram_re), 0);
    tick(); pop = 1'b0;
    chk("se_cnt", 32'(count), 1);
    chk("se_unf", 32'(underflow), 1);
    chk("se_rdv", 32'(rd_valid), 0);
    for (int i = 0; i < 4; i++) begin
      push_data = 8'h60 + 8'(i); tick();
    end
    chk("mid_cnt", 32'(count), 5);

    // simultaneous push+pop mid-range
    pop = 1'b1; push_data = 8'h77; #1;
    chk("mid_we", 32'(ram_we), 1);
    chk("mid_re", 32'(ram_re), 1);
    chk("mid_addr_ne", 32'(ram_wr_addr != ram_rd_addr), 1);
    tick(); push = 1'b0;
    chk("mid_cnt2", 32'(count), 5);
    chk("mid_rdv", 32'(rd_valid), 1);
    chk("mid_data", 32'(rd_data), 32'h55);

    // pop accepted in N, reset in N+1
    tick();
    pop = 1'b0; rst = 1'b1; #1;
    chk("rmid_rdv_n1", 32'(rd_valid), 0);
    tick();
    chk_reset_state("rmid");
    rst = 1'b0; tick();
    chk("rmid_rdv_after", 32'(rd_valid), 0);
    push = 1'b1; push_data = 8'h99; #1;
    chk("rmid_waddr", 32'(ram_wr_addr), 0);
    chk("rmid_we", 32'(ram_we), 1);
    tick(); push = 1'b0;
    chk("rmid_cnt", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
